key_event_fsm: RTL

KEY_EVENT_FSM -- requirements
Module: key_event_fsm

---
 rtl/key_event_fsm_if.sv | 18 +
 rtl/key_event_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/key_event_fsm_if.sv
// ---------------------------------------------------------------------------
// key_event_fsm_if
// Handshake bundle between the PS/2 receive FIFO and the key event decoder.
//   data       : scan-code byte at the FIFO head, valid while ready=1
//   ready      : FIFO non-empty
//   overflow   : FIFO overflow indication
//   nextdata_n : active-low pop strobe driven by the consumer
// master = FIFO side, slave = decoder side.
// ---------------------------------------------------------------------------
interface key_event_fsm_if;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;

  modport master (output data, ready, overflow, input nextdata_n);
  modport slave  (input data, ready, overflow, output nextdata_n);
endinterface

// File: rtl/key_event_fsm.sv
// ---------------------------------------------------------------------------
// key_event_fsm
// Decodes PS/2 set-2 scan codes popped from a receive FIFO into key press /
// release events for a single held key.
//
// Build option: define KEY_EVENT_EXT_EN to decode E0-prefixed (extended)
// keys. Without it, E0 bytes are popped and dropped and key_ext is tied 0.
//
// Ports
//   clk           : system clock, rising edge
//   clrn          : asynchronous active-low reset
//   fifo          : FIFO handshake (key_event_fsm_if.slave)
//   key_code      : make code of the most recently pressed key
//   key_valid     : key_code is currently held
//   key_ext       : held/last key carried an E0 prefix
//   key_count     : distinct presses, modulo 256
//   press_pulse   : one-cycle strobe on each counted press
//   release_pulse : one-cycle strobe on release of the held key
//   ovf_seen      : sticky FIFO overflow flag
//
// state   | meaning
// IDLE    | no prefix pending; next code byte is a make
// BRK     | F0 seen; next code byte is a break
// EXT     | E0 seen; next code byte is an extended make
// EXT_BRK | E0 then F0 seen; next code byte is an extended break
// ---------------------------------------------------------------------------
module key_event_fsm (
  input  logic                  clk,
  input  logic                  clrn,
  key_event_fsm_if.slave        fifo,
  output logic [7:0]            key_code,
  output logic                  key_valid,
  output logic                  key_ext,
  output logic [7:0]            key_count,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic                  ovf_seen
);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

`ifdef KEY_EVENT_EXT_EN
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
`else
  typedef enum logic {IDLE, BRK} state_t;
`endif

  state_t     state_q;
  logic       nextdata_n_q;
  logic [7:0] key_code_q;
  logic [7:0] key_count_q;
  logic       key_valid_q;
  logic       press_q;
  logic       release_q;
  logic       ovf_q;

  logic pop;
  logic is_break;
  logic cur_ext;
  logic same_key;

  // A pop can only be taken when the previous cycle was not itself a pop,
  // which enforces the two-cycle byte spacing.
  assign pop = fifo.ready & nextdata_n_q;

`ifdef KEY_EVENT_EXT_EN
  logic key_ext_q;
  assign is_break = (state_q == BRK) || (state_q == EXT_BRK);
  assign cur_ext  = (state_q == EXT) || (state_q == EXT_BRK);
  assign key_ext  = key_ext_q;
`else
  assign is_break = (state_q == BRK);
  assign cur_ext  = 1'b0;
  assign key_ext  = 1'b0;
`endif

  // Current byte names the key that is held right now (same code and prefix).
  assign same_key = key_valid_q && (fifo.data == key_code_q) && (cur_ext == key_ext);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      key_code_q   <= 8'h00;
      key_count_q  <= 8'h00;
      key_valid_q  <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef KEY_EVENT_EXT_EN
      key_ext_q    <= 1'b0;
`endif
    end else begin
      nextdata_n_q <= ~pop;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      if (fifo.overflow) begin
        ovf_q <= 1'b1;
      end
      if (pop) begin
        if (fifo.data == CODE_BRK) begin
          case (state_q)
            IDLE:    state_q <= BRK;
`ifdef KEY_EVENT_EXT_EN
            EXT:     state_q <= EXT_BRK;
`endif
            default: state_q <= state_q;
          endcase
        end else if (fifo.data == CODE_EXT) begin
`ifdef KEY_EVENT_EXT_EN
          state_q <= EXT;
`endif
        end else begin
          state_q <= IDLE;
          if (is_break) begin
            // Breaks for keys other than the held one are dropped.
            if (same_key) begin
              key_valid_q <= 1'b0;
              release_q   <= 1'b1;
            end
          end else if (!same_key) begin
            // A make equal to the held key is typematic repeat and is ignored.
            key_code_q  <= fifo.data;
            key_valid_q <= 1'b1;
            key_count_q <= key_count_q + 8'd1;
            press_q     <= 1'b1;
`ifdef KEY_EVENT_EXT_EN
            key_ext_q   <= cur_ext;
`endif
          end
        end
      end
    end
  end

  assign fifo.nextdata_n = nextdata_n_q;
  assign key_code        = key_code_q;
  assign key_valid       = key_valid_q;
  assign key_count       = key_count_q;
  assign press_pulse     = press_q;
  assign release_pulse   = release_q;
  assign ovf_seen        = ovf_q;

endmodule
